// File: rtl/control_unit_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the ALU system datapath.
// Optional CU_STORE16_EN macro: ST writes a full 16-bit word over T2/T3.
module control_unit_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic        InstrDone
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 2;

    localparam logic [OP_W-1:0] OP_BRA  = 6'h00;
    localparam logic [OP_W-1:0] OP_BNE  = 6'h01;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h02;
    localparam logic [OP_W-1:0] OP_MOVL = 6'h03;
    localparam logic [OP_W-1:0] OP_ADD  = 6'h04;
    localparam logic [OP_W-1:0] OP_SUB  = 6'h05;
    localparam logic [OP_W-1:0] OP_AND  = 6'h06;
    localparam logic [OP_W-1:0] OP_ORR  = 6'h07;
    localparam logic [OP_W-1:0] OP_LD   = 6'h08;
    localparam logic [OP_W-1:0] OP_ST   = 6'h09;
    localparam logic [OP_W-1:0] OP_HLT  = 6'h0A;

    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

    localparam logic [2:0] ARF_PC  = 3'b100;
    localparam logic [2:0] ARF_AR  = 3'b010;
    localparam logic [2:0] ARF_ALL = 3'b111;
    localparam logic [1:0] D_AR    = 2'b10;

    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_SUB    = 5'b10110;
    localparam logic [4:0] ALU_AND    = 5'b10111;
    localparam logic [4:0] ALU_ORR    = 5'b11000;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             s_bit;
    logic             flag_z;
    logic             branch_taken;
    logic             unused_bits;

    assign opcode = IROut[15:10];
    assign rx     = IROut[9:8];
    assign s_bit  = IROut[9];
    assign dst    = IROut[7:6];
    assign src1   = IROut[5:4];
    assign src2   = IROut[3:2];
    assign flag_z = Flags[3];

    assign unused_bits = ^{Flags[2:0], IROut[1:0]};

    assign branch_taken = (opcode == OP_BRA) ||
                          ((opcode == OP_BNE) && !flag_z) ||
                          ((opcode == OP_BEQ) &&  flag_z);

    // RF enable is one-hot with bit 3 selecting R1
    function automatic logic [3:0] reg_onehot(input logic [REG_W-1:0] r);
        return 4'b1000 >> r;
    endfunction

    function automatic logic [2:0] reg_sel(input logic [REG_W-1:0] r);
        return {1'b0, r};
    endfunction

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; every output starts from the idle value
    always_comb begin
        state_next  = state;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        InstrDone   = 1'b0;

        case (state)
            S_RST: begin
                ARF_RegSel = ARF_ALL;
                ARF_FunSel = FUN_CLEAR;
                RF_RegSel  = 4'b1111;
                RF_FunSel  = FUN_CLEAR;
                state_next = S_T0;
            end

            S_T0, S_T1: begin
                ARF_OutDSel = 2'b00;
                Mem_CS      = 1'b0;
                Mem_WR      = 1'b0;
                IR_Write    = 1'b1;
                IR_LH       = (state == S_T1);
                ARF_RegSel  = ARF_PC;
                ARF_FunSel  = FUN_INC;
                state_next  = (state == S_T0) ? S_T1 : S_T2;
            end

            S_T2: begin
                InstrDone  = 1'b1;
                state_next = S_T0;
                case (opcode)
                    OP_BRA, OP_BNE, OP_BEQ: begin
                        if (branch_taken) begin
                            MuxBSel    = 2'b11;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = ARF_PC;
                        end
                    end
                    OP_MOVL: begin
                        MuxASel   = 2'b11;
                        RF_FunSel = FUN_LOAD;
                        RF_RegSel = reg_onehot(rx);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        case (opcode)
                            OP_ADD:  ALU_FunSel = ALU_ADD;
                            OP_SUB:  ALU_FunSel = ALU_SUB;
                            OP_AND:  ALU_FunSel = ALU_AND;
                            default: ALU_FunSel = ALU_ORR;
                        endcase
                        RF_OutASel = reg_sel(src1);
                        RF_OutBSel = reg_sel(src2);
                        ALU_WF     = s_bit;
                        MuxASel    = 2'b00;
                        RF_FunSel  = FUN_LOAD;
                        RF_RegSel  = reg_onehot(dst);
                    end
                    OP_LD: begin
                        ARF_OutDSel = D_AR;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b0;
                        MuxASel     = 2'b10;
                        RF_FunSel   = FUN_LOAD;
                        RF_RegSel   = reg_onehot(rx);
                    end
                    OP_ST: begin
                        RF_OutASel  = reg_sel(rx);
                        ALU_FunSel  = ALU_PASS_A;
                        MuxCSel     = 1'b0;
                        ARF_OutDSel = D_AR;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
`ifdef CU_STORE16_EN
                        // Low byte now; AR steps so T3 addresses the high byte
                        ARF_RegSel  = ARF_AR;
                        ARF_FunSel  = FUN_INC;
                        InstrDone   = 1'b0;
                        state_next  = S_T3;
`endif
                    end
                    OP_HLT: begin
                        state_next = S_HALT;
                    end
                    default: begin
                    end
                endcase
            end

            S_T3: begin
`ifdef CU_STORE16_EN
                RF_OutASel  = reg_sel(rx);
                ALU_FunSel  = ALU_PASS_A;
                MuxCSel     = 1'b1;
                ARF_OutDSel = D_AR;
                Mem_CS      = 1'b0;
                Mem_WR      = 1'b1;
                InstrDone   = 1'b1;
`endif
                state_next  = S_T0;
            end

            S_HALT: begin
                Halted     = 1'b1;
                state_next = S_HALT;
            end

            default: begin
                state_next = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Directed bench for control_unit_sequencer; honours CU_STORE16_EN when defined.
module tb_control_unit_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted, InstrDone;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] a_sel;
        logic [2:0] b_sel;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] c_sel;
        logic [1:0] d_sel;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_wr;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
        logic       done;
    } cw_t;

    cw_t obs;

    control_unit_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
        .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
        .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
        .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halted(Halted), .InstrDone(InstrDone)
    );

    always #5 Clock = ~Clock;

    assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                  ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                  ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel,
                  MuxBSel, MuxCSel, Halted, InstrDone};

    task automatic check(input string tag, input cw_t got, input cw_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, 64'(got), 64'(exp));
        end
    endtask

    function automatic cw_t idle();
        cw_t c = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    function automatic cw_t rst_cw();
        cw_t c = idle();
        c.arf_reg = 3'b111;
        c.arf_fun = 3'b011;
        c.rf_reg  = 4'b1111;
        c.rf_fun  = 3'b011;
        return c;
    endfunction

    function automatic cw_t fetch(input logic lh);
        cw_t c = idle();
        c.mem_cs  = 1'b0;
        c.ir_wr   = 1'b1;
        c.ir_lh   = lh;
        c.arf_reg = 3'b100;
        c.arf_fun = 3'b001;
        return c;
    endfunction

    function automatic cw_t done_idle();
        cw_t c = idle();
        c.done = 1'b1;
        return c;
    endfunction

    function automatic cw_t branch();
        cw_t c = done_idle();
        c.mux_b   = 2'b11;
        c.arf_fun = 3'b010;
        c.arf_reg = 3'b100;
        return c;
    endfunction

    function automatic cw_t alu(input logic [4:0] f, input logic wf,
                                input logic [2:0] a, input logic [2:0] b,
                                input logic [3:0] r);
        cw_t c = done_idle();
        c.alu_fun = f;
        c.alu_wf  = wf;
        c.a_sel   = a;
        c.b_sel   = b;
        c.rf_fun  = 3'b010;
        c.rf_reg  = r;
        return c;
    endfunction

    // Fetch two bytes, present the instruction, then check the T2 decode
    task automatic run_instr(input string tag, input logic [15:0] ir,
                             input logic [3:0] fl, input cw_t exp_t2);
        @(negedge Clock);
        check({tag, "_t0"}, obs, fetch(1'b0));
        @(negedge Clock);
        check({tag, "_t1"}, obs, fetch(1'b1));
        IROut = ir;
        Flags = fl;
        @(negedge Clock);
        check({tag, "_t2"}, obs, exp_t2);
    endtask

    cw_t e;

    initial begin
        Reset = 1'b0;
        IROut = 16'h0000;
        Flags = 4'h0;
        repeat (3) @(negedge Clock);
        check("rst_low", obs, rst_cw());
        Reset = 1'b1;
        #1;
        check("rst_cycle", obs, rst_cw());

        e = done_idle();
        e.mux_a  = 2'b11;
        e.rf_fun = 3'b010;
        e.rf_reg = 4'b0100;
        run_instr("movl_r2", 16'h0D5A, 4'h0, e);

        run_instr("beq_taken",  16'h0840, 4'b1000, branch());
        run_instr("beq_not",    16'h0840, 4'b0000, done_idle());
        run_instr("bne_taken",  16'h0440, 4'b0111, branch());
        run_instr("bne_not",    16'h0440, 4'b1000, done_idle());
        run_instr("bra",        16'h0040, 4'b1000, branch());

        run_instr("add",  16'h12C4, 4'h0, alu(5'b10100, 1'b1, 3'b000, 3'b001, 4'b0001));
        run_instr("sub",  16'h142C, 4'h0, alu(5'b10110, 1'b0, 3'b010, 3'b011, 4'b1000));
        run_instr("orr",  16'h1E78, 4'h0, alu(5'b11000, 1'b1, 3'b011, 3'b010, 4'b0100));
        run_instr("and",  16'h1B10, 4'h0, alu(5'b10111, 1'b1, 3'b001, 3'b000, 4'b1000));

        e = done_idle();
        e.d_sel  = 2'b10;
        e.mem_cs = 1'b0;
        e.mux_a  = 2'b10;
        e.rf_fun = 3'b010;
        e.rf_reg = 4'b0010;
        run_instr("ld_r3", 16'h2200, 4'h0, e);

        e = done_idle();
        e.a_sel   = 3'b010;
        e.alu_fun = 5'b10000;
        e.d_sel   = 2'b10;
        e.mem_cs  = 1'b0;
        e.mem_wr  = 1'b1;
`ifdef CU_STORE16_EN
        e.done    = 1'b0;
        e.arf_reg = 3'b010;
        e.arf_fun = 3'b001;
        run_instr("st_r3", 16'h2600, 4'h0, e);
        e.done    = 1'b1;
        e.arf_reg = 3'b000;
        e.arf_fun = 3'b000;
        e.mux_c   = 1'b1;
        @(negedge Clock);
        check("st_t3", obs, e);
`else
        run_instr("st_r3", 16'h2600, 4'h0, e);
`endif

        run_instr("nop", 16'h2C00, 4'h0, done_idle());
        run_instr("hlt", 16'h2800, 4'h0, done_idle());

        e = idle();
        e.halted = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            check("halted", obs, e);
        end

        Reset = 1'b0;
        #1;
        check("rst_async", obs, rst_cw());
        @(negedge Clock);
        check("rst_hold", obs, rst_cw());
        Reset = 1'b1;
        @(negedge Clock);
        check("post_rst_t0", obs, fetch(1'b0));
        @(negedge Clock);
        check("post_rst_t1", obs, fetch(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit_sequencer.md
# control_unit_sequencer

Hardwired control unit sitting directly upstream of the ALU system datapath. It drives every datapath select, function and enable line; a separate instruction memory is not used. Each instruction runs as a fixed fetch / decode / execute sequence. The block fetches a 16-bit instruction into the datapath IR and decodes `IROut`. It then sequences branch, immediate-load, ALU, load and store micro-operations, using the ALU flags for conditional branches.

## Interface
Parameters: none.
- `Clock`  in  1  rising-edge clock; single clock domain.
- `Reset`  in  1  asynchronous, active-low reset.
- `IROut`  in  16  datapath IR contents.
- `Flags`  in  4  ALU flags {Z,C,N,O}; Z = `Flags[3]`.
- `RF_OutASel`, `RF_OutBSel`  out  3 each  RF read selects; 000..011 = R1..R4.
- `RF_FunSel`  out  3  RF function; 010 load, 011 clear.
- `RF_RegSel`, `RF_ScrSel`  out  4 each  one-hot enables, active-high; bit3 = R1/S1.
- `ALU_FunSel`  out  5  ALU operation.
- `ALU_WF`  out  1  flag write enable.
- `ARF_OutCSel`, `ARF_OutDSel`  out  2 each  00 PC, 01 SP, 10 AR.
- `ARF_FunSel`  out  3  001 increment, 010 load, 011 clear.
- `ARF_RegSel`  out  3  one-hot {PC,AR,SP}, active-high.
- `IR_LH`, `IR_Write`  out  1 each  IR byte select and write.
- `Mem_WR`, `Mem_CS`  out  1 each  1 = write; `Mem_CS` is active-low.
- `MuxASel`, `MuxBSel`  out  2 each  mux selects.
- `MuxCSel`  out  1  mux select.
- `Halted`  out  1  high in HALT.
- `InstrDone`  out  1  high in the last cycle of each instruction.

## Operation
- FSM states: RST, T0, T1, T2, T3, HALT. State is registered; outputs decode combinationally from state and `IROut`.
- IDLE outputs: all enables 0, `Mem_CS`=1, all selects and FunSels 0.
- RST (reset value of every output): `ARF_RegSel`=111 and `ARF_FunSel`=011; `RF_RegSel`=1111 and `RF_FunSel`=011; everything else IDLE; `Halted`=0; `InstrDone`=0. Next state: T0.
- T0: `ARF_OutDSel`=00, `Mem_CS`=0, `Mem_WR`=0, `IR_Write`=1, `IR_LH`=0, `ARF_RegSel`=100 with `ARF_FunSel`=001 (PC++). Next state: T1.
- T1: same as T0 with `IR_LH`=1. Next state: T2.
- Instruction formats:
  - Immediate: `IR[15:10]` op, `IR[9:8]` Rx, `IR[7:0]` value.
  - Register: `IR[9]` S, `IR[7:6]` DST, `IR[5:4]` SRC1, `IR[3:2]` SRC2.
- T2 execute, by opcode:
  - 0x00 BRA: `MuxBSel`=11, `ARF_FunSel`=010, `ARF_RegSel`=100.
  - 0x01 BNE: BRA if Z=0, else IDLE.
  - 0x02 BEQ: BRA if Z=1, else IDLE.
  - 0x03 MOVL: `MuxASel`=11, `RF_FunSel`=010, `RF_RegSel`=one-hot(Rx).
  - 0x04..0x07 ADD/SUB/AND/ORR: `ALU_FunSel`=10100/10110/10111/11000, `RF_OutASel`=SRC1, `RF_OutBSel`=SRC2, `ALU_WF`=S, `MuxASel`=00, `RF_FunSel`=010, `RF_RegSel`=one-hot(DST).
  - 0x08 LD: `ARF_OutDSel`=10, `Mem_CS`=0, `Mem_WR`=0, `MuxASel`=10, load Rx (zero-extended byte).
  - 0x09 ST: `RF_OutASel`=Rx, `ALU_FunSel`=10000 (pass A), `MuxCSel`=0, `ARF_OutDSel`=10, `Mem_CS`=0, `Mem_WR`=1.
  - 0x0A HLT: IDLE, next state HALT.
  - Other opcodes: NOP (IDLE).
- After T2 the next state is T0, except ST with the macro enabled (next state T3) and HLT (next state HALT).
- HALT: IDLE outputs, `Halted`=1; HALT is left only by reset.
- `InstrDone`=1 in T2 (or in T3 when present), and in the T2 of HLT.

## Timing
- Reset deassertion, then one RST cycle, then the first fetch. PC=0 at T0.
- Latency is 3 cycles per instruction; 4 for ST with the macro.
- The IR high byte is valid at the T1→T2 edge. The T2 decode uses the new `IROut`.
- Branch target is written at the end of T2; the next T0 fetches from the target.
- Flags are sampled in T2 only. A flag write in the same cycle does not affect the branch decision.
- Reset asserted mid-instruction: the state immediately becomes RST, and outputs take RST values asynchronously. A half-written ST leaves the low byte in memory.
- PC wraps 0xFFFF→0x0000 by datapath arithmetic; no special handling.

## Configuration
- `CU_STORE16_EN` defined:
  - ST stores 16 bits.
  - T2 writes the low byte and also asserts `ARF_RegSel`=010 with `ARF_FunSel`=001 (AR++).
  - T3 writes the high byte (`MuxCSel`=1) to AR+1, with AR unchanged.
- `CU_STORE16_EN` undefined: ST writes the low byte only in T2, with no AR change; T3 is unreachable.

## Test plan
- Reset low for 3 cycles, then high: RST outputs are seen, `ARF_RegSel`=111/`ARF_FunSel`=011; T0 follows 1 cycle later with `IR_Write`=1, `IR_LH`=0.
- MOVL R2,#0x5A (IR=0x0D5A): in T2, `MuxASel`=11, `RF_RegSel`=0100, `RF_FunSel`=010; `InstrDone`=1.
- BEQ 0x40: with Flags=1000, T2 gives `MuxBSel`=11, `ARF_RegSel`=100, `ARF_FunSel`=010; with Flags=0000, T2 outputs are IDLE.
- ADD S=1, DST=R4, SRC1=R1, SRC2=R2: `ALU_FunSel`=10100, `ALU_WF`=1, `RF_RegSel`=0001, `RF_OutASel`=000, `RF_OutBSel`=001.
- ST R3 with `CU_STORE16_EN`: T2 has `MuxCSel`=0, `Mem_WR`=1, AR++; T3 has `MuxCSel`=1, `Mem_WR`=1; without the macro, T3 never occurs.
- HLT, then a reset pulse during HALT: `Halted`=1 stays high for 10 or more cycles; reset returns the FSM to RST, then T0.
